dpram_fifo_ctrl: RTL and testbench
==================================

// Module: dpram_fifo_ctrl
// PURPOSE
//  Synchronous FIFO that acts as the client side of the 16x8 dual-port RAM.
//  It turns push/pop requests into write-port and read-port accesses on internal dual-port storage.
//  It owns the write/read pointers, occupancy count, full/empty flags and error pulses.
//  Storage is inferred inside this module, with one write port and one registered read port.
//  The block sits between a byte producer and a byte consumer in the same clock domain.
// PARAMETERS
//  DATA_W  8   data width in bits
//  ADDR_W  4   address width in bits; depth = 2**ADDR_W = 16 entries
// PORTS
//  clk        in   1         single clock; all state updates on posedge
//  rst_n      in   1         synchronous reset, active-low
//  wr_en      in   1         push request
//  wr_data    in   DATA_W    data to push; sampled on an accepted push
//  rd_en      in   1         pop request
//  rd_data    out  DATA_W    popped data; registered
//  rd_valid   out  1         rd_data holds a newly popped word this cycle
//  full       out  1         count == 2**ADDR_W
//  empty      out  1         count == 0
//  count      out  ADDR_W+1  current occupancy, 0..16
//  overflow   out  1         1-cycle pulse: push rejected
//  underflow  out  1         1-cycle pulse: pop rejected
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0.
//   - rd_valid=0, rd_data=0, overflow=0, underflow=0.
//   - Memory contents are not cleared.
//   - Reset mid-operation discards all stored entries and any in-flight pop result.
//   - rd_valid is 0 on the cycle after reset, even if rd_en was high before reset.
//  Pointers:
//   - wr_ptr and rd_ptr are ADDR_W+1 bits wide; the low ADDR_W bits address memory.
//   - Pointers wrap naturally modulo 2**(ADDR_W+1).
//   - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
//  Accept rules, evaluated on pre-edge state:
//   - push_ok = wr_en & (~full | rd_en)
//     A push into a full FIFO is accepted only when a pop is accepted in the same cycle.
//   - pop_ok = rd_en & ~empty
//     A pop from an empty FIFO is always rejected, even with a simultaneous push.
//     There is no write-to-read bypass.
//  On an accepted push:
//   - mem[wr_ptr[ADDR_W-1:0]] <= wr_data; wr_ptr increments.
//  On an accepted pop:
//   - rd_data <= mem[rd_ptr[ADDR_W-1:0]]; rd_ptr increments; rd_valid=1 on the next cycle.
//   - Latency is 1 cycle from the rd_en edge to valid rd_data.
//   - rd_data holds its last value while rd_valid=0.
//  count update:
//   - +1 on push only; -1 on pop only; unchanged on both or neither.
//   - Never exceeds 16 and never wraps.
//  Flags:
//   - full, empty and count are registered and reflect post-edge state.
//   - No almost-full or almost-empty flags.
//  Error pulses, each one cycle, registered:
//   - overflow  = wr_en & full & ~rd_en
//   - underflow = rd_en & empty
//   - Rejected requests change no state apart from the pulse.
//  Simultaneous push and pop:
//   - When 0 < count < 16, both are accepted and count is unchanged.
//   - When count == 16, both are accepted and full stays 1.
//   - When count == 0, only the push is accepted; count becomes 1 and underflow pulses.
// TESTING
//  1. After reset, push 0x00..0x0F to 16 entries -> full=1, count=16, empty=0, no overflow.
//  2. Push 0xAA while full, rd_en=0 -> overflow pulses 1 cycle; count=16; 0xAA is never read back.
//  3. Pop 16 times back-to-back -> rd_data=0x00..0x0F, each rd_valid=1 one cycle after its pop;
//     then empty=1, count=0.
//  4. Pop while empty -> underflow pulses; rd_valid=0; rd_data unchanged; pointers unchanged.
//  5. At count=5, push 0x55 and pop together -> count stays 5; popped word is the oldest entry.
//     Repeat at count=16 -> full stays 1. At count=0 -> count=1 and underflow pulses.
//  6. Wrap test: run 3 rounds of push 10 then pop 10 (pointers cross 16 and 32)
//     -> data order preserved. Then assert rst_n=0 at count=7 -> next cycle count=0, empty=1, rd_valid=0.

Source files
------------

// File: rtl/dpram_fifo_ctrl_if.sv
// Push/pop handshake bundle between a byte producer/consumer and the FIFO.
// master drives requests, slave (the FIFO) drives data and status.
interface dpram_fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en,
        output wr_data,
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  full,
        input  empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output rd_data,
        output rd_valid,
        output full,
        output empty,
        output count,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO over inferred 2**ADDR_W x DATA_W dual-port storage.
// One write port, one registered read port, registered flags and error pulses.
module dpram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dpram_fifo_ctrl_if.slave     bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              full_q;
    logic              empty_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              ovf_q;
    logic              udf_q;

    logic              push_ok;
    logic              pop_ok;
    logic [ADDR_W:0]   wr_ptr_n;
    logic [ADDR_W:0]   rd_ptr_n;
    logic [ADDR_W:0]   count_n;
    logic              full_n;
    logic              empty_n;
    logic              ovf_n;
    logic              udf_n;

    always_comb begin
        push_ok = bus.wr_en & (~full_q | bus.rd_en);
        pop_ok  = bus.rd_en & ~empty_q;
        ovf_n   = bus.wr_en & full_q & ~bus.rd_en;
        udf_n   = bus.rd_en & empty_q;

        wr_ptr_n = push_ok ? wr_ptr + ONE : wr_ptr;
        rd_ptr_n = pop_ok  ? rd_ptr + ONE : rd_ptr;

        count_n = count_q;
        unique case (1'b1)
            push_ok & ~pop_ok: count_n = count_q + ONE;
            pop_ok & ~push_ok: count_n = count_q - ONE;
            default:           count_n = count_q;
        endcase

        // Extra pointer MSB separates full from empty when low bits match
        empty_n = (wr_ptr_n == rd_ptr_n);
        full_n  = (wr_ptr_n[ADDR_W] != rd_ptr_n[ADDR_W]) &&
                  (wr_ptr_n[ADDR_W-1:0] == rd_ptr_n[ADDR_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            count_q    <= count_n;
            full_q     <= full_n;
            empty_q    <= empty_n;
            rd_valid_q <= pop_ok;
            ovf_q      <= ovf_n;
            udf_q      <= udf_n;
            if (pop_ok) begin
                rd_data_q <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_dpram_fifo_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dpram_fifo_ctrl_if bus ();

    dpram_fifo_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored bytes
    logic [7:0] q[$];
    logic [7:0] m_rd_data;
    logic       m_rd_valid;
    logic       m_ovf;
    logic       m_udf;
    bit         started = 0;

    always @(posedge clk) begin
        bit f, e, push, pop;
        if (!rst_n) begin
            q.delete();
            m_rd_data  = 8'h00;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
            m_udf      = 1'b0;
            started    = 1;
        end else begin
            f    = (q.size() == 16);
            e    = (q.size() == 0);
            push = bus.wr_en && (!f || bus.rd_en);
            pop  = bus.rd_en && !e;
            m_ovf = bus.wr_en && f && !bus.rd_en;
            m_udf = bus.rd_en && e;
            m_rd_valid = pop;
            if (pop) m_rd_data = q.pop_front();
            if (push) q.push_back(bus.wr_data);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_count", 32'(bus.count), 32'(q.size()));
            chk("m_full", 32'(bus.full), 32'(q.size() == 16));
            chk("m_empty", 32'(bus.empty), 32'(q.size() == 0));
            chk("m_rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
            chk("m_rd_data", 32'(bus.rd_data), 32'(m_rd_data));
            chk("m_overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("m_underflow", 32'(bus.underflow), 32'(m_udf));
        end
    end

    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_en   = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        rst_n = 1'b1;

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
        chk("fill_count", 32'(bus.count), 32'd16);
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_empty", 32'(bus.empty), 32'd0);
        chk("fill_ovf", 32'(bus.overflow), 32'd0);

        // Push while full
        cyc(1'b1, 8'hAA, 1'b0);
        chk("ovf_pulse", 32'(bus.overflow), 32'd1);
        chk("ovf_count", 32'(bus.count), 32'd16);
        cyc(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(bus.overflow), 32'd0);

        // Drain back-to-back
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(bus.rd_data), 32'(i));
            chk("drain_valid", 32'(bus.rd_valid), 32'd1);
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_count", 32'(bus.count), 32'd0);

        // Pop while empty
        cyc(1'b0, 8'h00, 1'b1);
        chk("udf_pulse", 32'(bus.underflow), 32'd1);
        chk("udf_valid", 32'(bus.rd_valid), 32'd0);
        chk("udf_data", 32'(bus.rd_data), 32'h0F);
        cyc(1'b0, 8'h00, 1'b0);
        chk("udf_clear", 32'(bus.underflow), 32'd0);

        // Simultaneous push/pop at count 5
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
        cyc(1'b1, 8'h55, 1'b1);
        chk("both5_count", 32'(bus.count), 32'd5);
        chk("both5_data", 32'(bus.rd_data), 32'h20);

        // Simultaneous push/pop at count 16
        for (int i = 0; i < 11; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
        cyc(1'b1, 8'h66, 1'b1);
        chk("both16_full", 32'(bus.full), 32'd1);
        chk("both16_count", 32'(bus.count), 32'd16);
        chk("both16_data", 32'(bus.rd_data), 32'h21);
        chk("both16_ovf", 32'(bus.overflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("drain2_first", 32'(bus.rd_data), 32'h22);
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("drain2_last", 32'(bus.rd_data), 32'h66);

        // Simultaneous push/pop at count 0
        cyc(1'b1, 8'h77, 1'b1);
        chk("both0_count", 32'(bus.count), 32'd1);
        chk("both0_udf", 32'(bus.underflow), 32'd1);
        chk("both0_valid", 32'(bus.rd_valid), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("both0_pop", 32'(bus.rd_data), 32'h77);

        // Wrap rounds
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 10; j++) cyc(1'b1, 8'(r * 16 + j), 1'b0);
            for (int j = 0; j < 10; j++) begin
                cyc(1'b0, 8'h00, 1'b1);
                chk("wrap_data", 32'(bus.rd_data), 32'(r * 16 + j));
            end
        end

        // Reset mid-operation with a pop pending
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'd7);
        rst_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b1);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        chk("post_rst_valid", 32'(bus.rd_valid), 32'd0);

        // Mixed traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        cyc(1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
